// File: rtl/video_pipe_pkg.sv
// video_pipe_pkg: register map, field positions and pipeline beat type shared by the video stream pipeline.
package video_pipe_pkg;
    localparam logic [1:0] REG_CTRL      = 2'd0;
    localparam logic [1:0] REG_STATUS    = 2'd1;
    localparam logic [1:0] REG_FRAME_CNT = 2'd2;
    localparam logic [1:0] REG_LEN_ERR   = 2'd3;
    localparam int CTRL_PAUSE  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_CH_LSB = 8;
    localparam int ST_PAUSED   = 0;
    localparam int ST_IRQ      = 1;
    localparam int ST_LEN_ERR  = 2;
    localparam int ST_CH_LSB   = 8;
    localparam int PIX_W       = 16;
    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic             sop;
        logic             eop;
    } beat_t;
endpackage

// File: rtl/video_pipe_stage.sv
// video_pipe_stage: one stall-able pipeline register holding a beat; loads whenever it is empty or downstream is ready.
module video_pipe_stage
#(
    parameter type beat_t = video_pipe_pkg::beat_t
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  valid_i,
    input  beat_t beat_i,
    input  logic  rdy_i,
    output logic  valid_o,
    output beat_t beat_o,
    output logic  rdy_o
);
    logic  valid_q;
    beat_t beat_q;

    assign rdy_o   = ~valid_q | rdy_i;
    assign valid_o = valid_q;
    assign beat_o  = beat_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else if (rdy_o) begin
            valid_q <= valid_i;
            beat_q  <= beat_i;
        end
    end
endmodule

// File: rtl/video_stream_mux_pipe.sv
// video_stream_mux_pipe: frame-aligned NUM_CH:1 Avalon-ST mux feeding a PIPE_DEPTH-stage stallable pipeline, with pause/irq control over Avalon-MM.
// Optional frame length checker enabled by defining VIDEO_LEN_CHECK_EN.
module video_stream_mux_pipe
    import video_pipe_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int NUM_CH       = 2,
    parameter int PIPE_DEPTH   = 6,
    parameter int FRAME_PIXELS = 76800
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     irq_sender,
    input  logic                     chipselect,
    input  logic                     read,
    input  logic                     write,
    input  logic [1:0]               address,
    input  logic [31:0]              writedata,
    output logic [31:0]              readdata,
    input  logic [NUM_CH-1:0]        sink_valid_in,
    output logic [NUM_CH-1:0]        sink_ready_out,
    input  logic [NUM_CH*DATA_W-1:0] sink_data_in,
    input  logic [NUM_CH-1:0]        sink_startofpacket_in,
    input  logic [NUM_CH-1:0]        sink_endofpacket_in,
    output logic                     source_valid_out,
    input  logic                     source_ready_in,
    output logic [DATA_W-1:0]        source_data_out,
    output logic                     source_startofpacket_out,
    output logic                     source_endofpacket_out
);
    localparam logic [3:0] MAX_CH = 4'(NUM_CH - 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } pix_beat_t;

    logic        pause_req_q, irq_en_q, in_frame_q, gate_q, paused_q, irq_pending_q;
    logic [3:0]  ch_sel_q, active_ch_q, ch_clamp;
    logic [15:0] frame_cnt_q, len_err_cnt;
    logic [31:0] readdata_q, rd_d;
    logic        len_err, len_err_set;
    logic        sel_valid, accept, fwd, in_frame_d, gate_d, paused, src_eop, wr_ctrl, wr_status;
    pix_beat_t   sel_beat;
    logic [PIPE_DEPTH:0] valid, rdy;
    pix_beat_t   beat [PIPE_DEPTH+1];
    logic        unused_wd;

    assign unused_wd = ^{writedata[31:12], writedata[7:3]};

    always_comb begin
        sel_valid      = 1'b0;
        sel_beat       = '0;
        sink_ready_out = '1;
        for (int c = 0; c < NUM_CH; c++)
            if (active_ch_q == 4'(c)) begin
                sel_valid         = sink_valid_in[c];
                sel_beat          = '{data: sink_data_in[c*DATA_W +: DATA_W],
                                      sop: sink_startofpacket_in[c], eop: sink_endofpacket_in[c]};
                sink_ready_out[c] = rdy[0] & gate_q;
            end
    end

    // Beats outside a frame that do not open one are swallowed to resync on the next SOP.
    assign accept     = sel_valid & rdy[0] & gate_q;
    assign fwd        = accept & (in_frame_q | sel_beat.sop);
    assign in_frame_d = accept ? (sel_beat.sop ? ~sel_beat.eop : in_frame_q & ~sel_beat.eop) : in_frame_q;
    assign gate_d     = ~pause_req_q | (gate_q & in_frame_d);
    assign paused     = ~gate_q & ~|valid[PIPE_DEPTH:1];
    assign ch_clamp   = (ch_sel_q > MAX_CH) ? MAX_CH : ch_sel_q;
    assign src_eop    = valid[PIPE_DEPTH] & source_ready_in & beat[PIPE_DEPTH].eop;
    assign wr_ctrl    = chipselect & write & (address == REG_CTRL);
    assign wr_status  = chipselect & write & (address == REG_STATUS);

    assign valid[0]         = fwd;
    assign beat[0]          = sel_beat;
    assign rdy[PIPE_DEPTH]  = source_ready_in;

    for (genvar s = 0; s < PIPE_DEPTH; s++) begin : g_stage
        video_pipe_stage #(.beat_t(pix_beat_t)) u_stage (
            .clk(clk), .reset(reset),
            .valid_i(valid[s]), .beat_i(beat[s]), .rdy_i(rdy[s+1]),
            .valid_o(valid[s+1]), .beat_o(beat[s+1]), .rdy_o(rdy[s])
        );
    end

    assign source_valid_out         = valid[PIPE_DEPTH];
    assign source_data_out          = beat[PIPE_DEPTH].data;
    assign source_startofpacket_out = beat[PIPE_DEPTH].sop;
    assign source_endofpacket_out   = beat[PIPE_DEPTH].eop;
    assign irq_sender               = irq_pending_q & irq_en_q;
    assign readdata                 = readdata_q;

    assign rd_d = (address == REG_CTRL)      ? {20'd0, ch_sel_q, 6'd0, irq_en_q, pause_req_q} :
                  (address == REG_STATUS)    ? {20'd0, active_ch_q, 5'd0, len_err, irq_pending_q, paused} :
                  (address == REG_FRAME_CNT) ? {16'd0, frame_cnt_q} : {16'd0, len_err_cnt};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pause_req_q   <= 1'b0;
            irq_en_q      <= 1'b0;
            ch_sel_q      <= '0;
            active_ch_q   <= '0;
            in_frame_q    <= 1'b0;
            gate_q        <= 1'b1;
            paused_q      <= 1'b0;
            irq_pending_q <= 1'b0;
            frame_cnt_q   <= '0;
            readdata_q    <= '0;
        end else begin
            in_frame_q    <= in_frame_d;
            gate_q        <= gate_d;
            paused_q      <= paused;
            irq_pending_q <= (paused & ~paused_q) | len_err_set | (irq_pending_q & ~(wr_status & writedata[ST_IRQ]));
            if (!in_frame_q && !(accept && sel_beat.sop))
                active_ch_q <= ch_clamp;
            if (wr_ctrl) begin
                pause_req_q <= writedata[CTRL_PAUSE];
                irq_en_q    <= writedata[CTRL_IRQ_EN];
                ch_sel_q    <= writedata[CTRL_CH_LSB +: 4];
            end
            if (src_eop)
                frame_cnt_q <= frame_cnt_q + 16'd1;
            if (chipselect && read)
                readdata_q <= rd_d;
        end
    end

`ifdef VIDEO_LEN_CHECK_EN
    logic [31:0] pix_cnt_q, pix_cnt_d;
    logic [15:0] len_err_cnt_q;
    logic        len_err_q;

    assign pix_cnt_d   = sel_beat.sop ? 32'd1 : pix_cnt_q + 32'd1;
    assign len_err_set = fwd & sel_beat.eop & (pix_cnt_d != 32'(FRAME_PIXELS));
    assign len_err_cnt = len_err_cnt_q;
    assign len_err     = len_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_cnt_q     <= '0;
            len_err_cnt_q <= '0;
            len_err_q     <= 1'b0;
        end else begin
            if (fwd)
                pix_cnt_q <= pix_cnt_d;
            if (len_err_set && len_err_cnt_q != 16'hFFFF)
                len_err_cnt_q <= len_err_cnt_q + 16'd1;
            len_err_q <= len_err_set | (len_err_q & ~(wr_status & writedata[ST_LEN_ERR]));
        end
    end
`else
    localparam int unused_frame_pixels = FRAME_PIXELS;
    logic unused_len;
    assign unused_len  = writedata[ST_LEN_ERR];
    assign len_err_set = 1'b0;
    assign len_err_cnt = '0;
    assign len_err     = 1'b0;
`endif
endmodule

// File: tb/tb_video_stream_mux_pipe.sv
// tb_video_stream_mux_pipe: directed scenarios checked against a frame-level expected-beat queue plus literal register expectations.
module tb_video_stream_mux_pipe;
    logic        clk = 1'b0, reset = 1'b1;
    logic        chipselect = 1'b0, read = 1'b0, write = 1'b0;
    logic [1:0]  address = '0;
    logic [31:0] writedata = '0, readdata;
    logic        irq_sender;
    logic [1:0]  sink_valid_in = '0, sink_ready_out, sink_sop = '0, sink_eop = '0;
    logic [31:0] sink_data_in = '0;
    logic        source_valid_out, source_ready_in = 1'b1, src_sop, src_eop;
    logic [15:0] source_data_out;

    int total = 0, bad = 0, cyc = 0, out_cnt = 0;
    logic [15:0] last_out = '0;
    logic [17:0] exp_q [$];
    int m_active = 0, m_ch_sel = 0;
    logic m_in_frame = 1'b0;
    logic tog = 1'b0;

    video_stream_mux_pipe #(.DATA_W(16), .NUM_CH(2), .PIPE_DEPTH(6), .FRAME_PIXELS(8)) dut (
        .clk(clk), .reset(reset), .irq_sender(irq_sender),
        .chipselect(chipselect), .read(read), .write(write), .address(address),
        .writedata(writedata), .readdata(readdata),
        .sink_valid_in(sink_valid_in), .sink_ready_out(sink_ready_out), .sink_data_in(sink_data_in),
        .sink_startofpacket_in(sink_sop), .sink_endofpacket_in(sink_eop),
        .source_valid_out(source_valid_out), .source_ready_in(source_ready_in),
        .source_data_out(source_data_out), .source_startofpacket_out(src_sop), .source_endofpacket_out(src_eop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired, required event never happened", name);
    endtask

    // Frame-level reference: accepted beats on the active channel become expected output beats if they belong to a frame.
    always @(negedge clk) begin
        logic [17:0] eb;
        logic bs, be, acc_sop, nxt;
        if (reset) begin
            exp_q.delete();
            m_in_frame = 1'b0;
            m_active = 0;
            m_ch_sel = 0;
        end else begin
            if (source_valid_out && source_ready_in) begin
                out_cnt++;
                last_out = source_data_out;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got data 0x%0h, required no beat", source_data_out);
                end else begin
                    eb = exp_q.pop_front();
                    chk("out_beat", {14'd0, source_data_out, src_sop, src_eop}, {14'd0, eb});
                end
            end
            for (int c = 0; c < 2; c++)
                if (c != m_active) chk("idle_ready", 32'(sink_ready_out[c]), 32'd1);
            acc_sop = 1'b0;
            nxt = m_in_frame;
            if (sink_valid_in[m_active] && sink_ready_out[m_active]) begin
                bs = sink_sop[m_active];
                be = sink_eop[m_active];
                if (m_in_frame || bs) exp_q.push_back({sink_data_in[m_active*16 +: 16], bs, be});
                acc_sop = bs;
                nxt = bs ? !be : (m_in_frame && !be);
            end
            if (!m_in_frame && !acc_sop) m_active = (m_ch_sel > 1) ? 1 : m_ch_sel;
            m_in_frame = nxt;
            if (chipselect && write && address == 2'd0) m_ch_sel = int'(writedata[11:8]);
        end
    end

    task automatic send(input int ch, input logic [15:0] d, input logic s, input logic e);
        int n = 0;
        sink_valid_in[ch] = 1'b1;
        sink_data_in[ch*16 +: 16] = d;
        sink_sop[ch] = s;
        sink_eop[ch] = e;
        @(negedge clk);
        while (!sink_ready_out[ch] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) flag("send_timeout");
        @(posedge clk); #1;
        sink_valid_in[ch] = 1'b0;
    endtask

    task automatic send_frame(input int ch, input logic [15:0] base, input int len);
        for (int i = 0; i < len; i++) send(ch, base + 16'(i), i == 0, i == len - 1);
    endtask

    task automatic wait_drain;
        int n = 0;
        while ((exp_q.size() != 0 || source_valid_out) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) flag("drain_timeout");
        @(posedge clk); #1;
    endtask

    task automatic mm_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic mm_read(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(posedge clk); #1;
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [31:0] r;
        int t0, n;
        idle(3);
        reset = 1'b0;
        idle(1);
        chk("rst_src_valid", 32'(source_valid_out), 0);
        chk("rst_irq", 32'(irq_sender), 0);
        chk("rst_readdata", readdata, 0);
        mm_read(2'd0, r); chk("rst_ctrl", r, 0);
        mm_read(2'd1, r); chk("rst_status", r, 0);
        mm_read(2'd2, r); chk("rst_frame_cnt", r, 0);

        // 8-pixel frame, no backpressure, latency 6
        t0 = cyc;
        fork
            send_frame(0, 16'h0100, 8);
            begin
                n = 0;
                while (!source_valid_out && n < 50) begin @(negedge clk); n++; end
                chk("latency", 32'(cyc - t0), 6);
                chk("first_pixel", {16'd0, source_data_out}, 32'h0100);
            end
        join
        wait_drain();
        chk("t1_last", {16'd0, last_out}, 32'h0107);
        mm_read(2'd2, r); chk("t1_frame_cnt", r, 1);

        // same frame with toggling downstream ready
        tog = 1'b1;
        out_cnt = 0;
        fork
            begin send_frame(0, 16'h0200, 8); wait_drain(); tog = 1'b0; end
            while (tog) begin @(posedge clk); #1; source_ready_in = ~source_ready_in; end
        join
        source_ready_in = 1'b1;
        idle(4);
        chk("t1b_count", 32'(out_cnt), 8);
        chk("t1b_last", {16'd0, last_out}, 32'h0207);
        mm_read(2'd2, r); chk("t1b_frame_cnt", r, 2);

        // switch to ch1 mid-frame, ch1 idling with non-SOP filler
        sink_valid_in[1] = 1'b1; sink_data_in[31:16] = 16'hDEAD; sink_sop[1] = 1'b0; sink_eop[1] = 1'b0;
        for (int i = 0; i < 3; i++) send(0, 16'h0300 + 16'(i), i == 0, 1'b0);
        mm_write(2'd0, 32'h100);
        for (int i = 3; i < 8; i++) send(0, 16'h0300 + 16'(i), 1'b0, i == 7);
        idle(1);
        mm_read(2'd1, r); chk("t2_status_ch", r, 32'h100);
        sink_valid_in[1] = 1'b0;
        send_frame(1, 16'h0400, 8);
        wait_drain();
        chk("t2_last", {16'd0, last_out}, 32'h0407);
        mm_read(2'd2, r); chk("t2_frame_cnt", r, 4);
        mm_write(2'd0, 32'h500);
        idle(2);
        mm_read(2'd1, r); chk("t2_clamp", r, 32'h100);
        mm_write(2'd0, 32'h000);
        idle(2);
        mm_read(2'd1, r); chk("t2_back_ch0", r, 32'h000);

        // pause at end of frame
        for (int i = 0; i < 4; i++) send(0, 16'h0500 + 16'(i), i == 0, 1'b0);
        mm_write(2'd0, 32'h003);
        for (int i = 4; i < 8; i++) send(0, 16'h0500 + 16'(i), 1'b0, i == 7);
        chk("t3_ready_drop", 32'(sink_ready_out[0]), 0);
        idle(10);
        chk("t3_irq", 32'(irq_sender), 1);
        mm_read(2'd1, r); chk("t3_status", r, 32'h003);
        mm_write(2'd1, 32'h002);
        chk("t3_irq_clr", 32'(irq_sender), 0);
        mm_read(2'd1, r); chk("t3_status_clr", r, 32'h001);
        mm_write(2'd0, 32'h002);
        idle(1);
        chk("t3_ready_back", 32'(sink_ready_out[0]), 1);
        send_frame(0, 16'h0600, 3);
        wait_drain();
        chk("t3_last", {16'd0, last_out}, 32'h0602);
        mm_read(2'd2, r); chk("t3_frame_cnt", r, 6);

        // orphan beats are dropped
        out_cnt = 0;
        for (int i = 0; i < 3; i++) send(0, 16'h0700 + 16'(i), 1'b0, i == 2);
        send_frame(0, 16'h0710, 3);
        wait_drain();
        chk("t4_count", 32'(out_cnt), 3);
        chk("t4_last", {16'd0, last_out}, 32'h0712);
        mm_read(2'd2, r); chk("t4_frame_cnt", r, 7);

        // reset mid-frame with data held at the source
        source_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) send(0, 16'h0800 + 16'(i), i == 0, 1'b0);
        idle(6);
        chk("t5_held_valid", 32'(source_valid_out), 1);
        chk("t5_held_data", {16'd0, source_data_out}, 32'h0800);
        reset = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(source_valid_out), 0);
        chk("t5_rst_readdata", readdata, 0);
        idle(2);
        reset = 1'b0;
        source_ready_in = 1'b1;
        idle(1);
        out_cnt = 0;
        send(0, 16'h0804, 1'b0, 1'b0);
        send(0, 16'h0805, 1'b0, 1'b1);
        send_frame(0, 16'h0900, 8);
        wait_drain();
        chk("t5_count", 32'(out_cnt), 8);
        chk("t5_last", {16'd0, last_out}, 32'h0907);
        mm_read(2'd2, r); chk("t5_frame_cnt", r, 1);

`ifdef VIDEO_LEN_CHECK_EN
        mm_read(2'd3, r); chk("t6_len_err_init", r, 0);
        send_frame(0, 16'h0A00, 7);
        wait_drain();
        mm_read(2'd3, r); chk("t6_len_err_cnt", r, 1);
        mm_read(2'd1, r); chk("t6_status_len", 32'(r[2]), 1);
        send_frame(0, 16'h0B00, 8);
        wait_drain();
        mm_read(2'd3, r); chk("t6_len_err_keep", r, 1);
`else
        send_frame(0, 16'h0A00, 7);
        wait_drain();
        mm_read(2'd3, r); chk("t6_reg3_zero", r, 0);
        mm_read(2'd1, r); chk("t6_status_len", 32'(r[2]), 0);
`endif
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
